// File: rtl/usb_uart_ctrl.sv
// USB-UART controller for the NORA $9F55-$9F57 window: CTRL/STAT/DATA registers,
// TX/RX byte FIFOs, 8N1 serialiser/deserialiser and optional CTS/RTS flow control.

module usb_uart_fifo #(
  parameter int unsigned DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [7:0]             wdata,
  input  logic                   pop,
  output logic [7:0]             rdata,
  output logic [$clog2(DEPTH):0] count
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [7:0]  mem_q [DEPTH];
  logic [AW:0] wp_q, wp_d, rp_q, rp_d;
  logic        empty, full, push_ok, pop_ok;

  // A pop on a full FIFO frees the slot a same-cycle push then takes.
  always_comb begin
    empty   = (wp_q == rp_q);
    full    = (wp_q[AW] != rp_q[AW]) && (wp_q[AW-1:0] == rp_q[AW-1:0]);
    pop_ok  = pop && !empty;
    push_ok = push && (!full || pop_ok);
    wp_d    = push_ok ? wp_q + PTR_ONE : wp_q;
    rp_d    = pop_ok  ? rp_q + PTR_ONE : rp_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wp_q <= '0;
      rp_q <= '0;
    end else begin
      wp_q <= wp_d;
      rp_q <= rp_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wp_q[AW-1:0]] <= wdata;
  end

  assign rdata = mem_q[rp_q[AW-1:0]];
  assign count = wp_q - rp_q;
endmodule

module usb_uart_ctrl #(
  parameter int unsigned CLK_HZ     = 48_000_000,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       reg_cs,
  input  logic [1:0] reg_addr,
  input  logic       reg_wr_pulse,
  input  logic       reg_rd_pulse,
  input  logic [7:0] reg_wdata,
  output logic [7:0] reg_rdata,
  input  logic       uart_rx,
  input  logic       uart_cts_n,
  output logic       uart_tx,
  output logic       uart_rts_n
);
  localparam int unsigned AW = $clog2(FIFO_DEPTH);

  function automatic int unsigned div_of(input int unsigned baud);
    int unsigned d;
    d = (CLK_HZ + baud / 2) / baud;
    return (d == 0) ? 1 : d;
  endfunction

  localparam int unsigned   DW      = $clog2(div_of(9600) + 1);
  localparam logic [DW-1:0] DW_ONE  = {{(DW-1){1'b0}}, 1'b1};
  localparam logic [AW:0]   RTS_LVL = (AW+1)'(FIFO_DEPTH - 2);

  // Register decode
  logic ctrl_wr, data_wr, stat_rd, data_rd;
  assign ctrl_wr = reg_cs && reg_wr_pulse && (reg_addr == 2'd0);
  assign data_wr = reg_cs && reg_wr_pulse && (reg_addr == 2'd2);
  assign stat_rd = reg_cs && reg_rd_pulse && (reg_addr == 2'd1);
  assign data_rd = reg_cs && reg_rd_pulse && (reg_addr == 2'd2);

  logic [3:0] ctrl_q, ctrl_d;
  logic       ovr_q, ovr_d, ferr_q, ferr_d, rts_q, rts_d;

  // Input synchronisers
  logic rx_meta_q, rx_sync_q, rx_prev_q;
  logic cts_meta_q, cts_sync_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= uart_rx;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
    end
  end

  always_ff @(posedge clk) begin
    cts_meta_q <= uart_cts_n;
    cts_sync_q <= cts_meta_q;
  end

  logic [DW-1:0] div_sel;
  always_comb begin
    case (ctrl_q[2:0])
      3'd0:    div_sel = DW'(div_of(9600));
      3'd1:    div_sel = DW'(div_of(19200));
      3'd2:    div_sel = DW'(div_of(38400));
      3'd3:    div_sel = DW'(div_of(57600));
      3'd4:    div_sel = DW'(div_of(115200));
      3'd5:    div_sel = DW'(div_of(230400));
      3'd6:    div_sel = DW'(div_of(1000000));
      default: div_sel = DW'(div_of(3000000));
    endcase
  end

  // FIFOs
  logic [7:0] tx_head, rx_head, rx_byte;
  logic [AW:0] tx_count, rx_count;
  logic tx_pop, rx_push;
  logic tx_empty, tx_full, rx_empty, rx_full;

  usb_uart_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (data_wr),
    .wdata (reg_wdata),
    .pop   (tx_pop),
    .rdata (tx_head),
    .count (tx_count)
  );

  usb_uart_fifo #(.DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (rx_push),
    .wdata (rx_byte),
    .pop   (data_rd),
    .rdata (rx_head),
    .count (rx_count)
  );

  assign tx_empty = (tx_count == '0);
  assign tx_full  = tx_count[AW];
  assign rx_empty = (rx_count == '0);
  assign rx_full  = rx_count[AW];

  // Transmitter
  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;
  tx_state_e     tx_state_q;
  logic [DW-1:0] tx_div_q, tx_cnt_q;
  logic [2:0]    tx_bit_q;
  logic [7:0]    tx_shift_q;
  logic          tx_line_q, tx_busy_q;
  logic          tx_bit_end, tx_start;

  // The end of STOP may chain straight into the next START with no idle gap.
  always_comb begin
    tx_bit_end = (tx_cnt_q == tx_div_q - DW_ONE);
    tx_start   = ((tx_state_q == TX_IDLE) || ((tx_state_q == TX_STOP) && tx_bit_end))
                 && !tx_empty && (!ctrl_q[3] || !cts_sync_q);
    tx_pop     = tx_start;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state_q <= TX_IDLE;
      tx_div_q   <= '0;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      tx_line_q  <= 1'b1;
      tx_busy_q  <= 1'b0;
    end else begin
      tx_line_q <= (tx_state_q == TX_START) ? 1'b0 :
                   (tx_state_q == TX_DATA)  ? tx_shift_q[0] : 1'b1;
      tx_busy_q <= (tx_state_q != TX_IDLE);
      if (tx_start) begin
        tx_state_q <= TX_START;
        tx_div_q   <= div_sel;
        tx_cnt_q   <= '0;
        tx_shift_q <= tx_head;
      end else begin
        case (tx_state_q)
          TX_START: begin
            if (tx_bit_end) begin
              tx_state_q <= TX_DATA;
              tx_cnt_q   <= '0;
              tx_bit_q   <= '0;
            end else begin
              tx_cnt_q <= tx_cnt_q + DW_ONE;
            end
          end
          TX_DATA: begin
            if (tx_bit_end) begin
              tx_cnt_q   <= '0;
              tx_shift_q <= {1'b0, tx_shift_q[7:1]};
              if (tx_bit_q == 3'd7) tx_state_q <= TX_STOP;
              else                  tx_bit_q   <= tx_bit_q + 3'd1;
            end else begin
              tx_cnt_q <= tx_cnt_q + DW_ONE;
            end
          end
          TX_STOP: begin
            if (tx_bit_end) tx_state_q <= TX_IDLE;
            else            tx_cnt_q   <= tx_cnt_q + DW_ONE;
          end
          default: tx_state_q <= TX_IDLE;
        endcase
      end
    end
  end

  // Receiver
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;
  rx_state_e     rx_state_q;
  logic [DW-1:0] rx_div_q, rx_cnt_q, rx_half;
  logic [2:0]    rx_bit_q;
  logic [7:0]    rx_shift_q;
  logic          rx_fall, rx_bit_end, rx_stop_smp, ovr_evt, ferr_evt;

  always_comb begin
    rx_fall     = rx_prev_q && !rx_sync_q;
    rx_half     = ((rx_div_q >> 1) == '0) ? '0 : (rx_div_q >> 1) - DW_ONE;
    rx_bit_end  = (rx_cnt_q == rx_div_q - DW_ONE);
    rx_stop_smp = (rx_state_q == RX_STOP) && rx_bit_end;
    rx_push     = rx_stop_smp && rx_sync_q;
    rx_byte     = rx_shift_q;
    ferr_evt    = rx_stop_smp && !rx_sync_q;
    ovr_evt     = rx_push && rx_full && !data_rd;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_state_q <= RX_IDLE;
      rx_div_q   <= '0;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
    end else begin
      case (rx_state_q)
        RX_IDLE: begin
          if (rx_fall) begin
            rx_state_q <= RX_START;
            rx_div_q   <= div_sel;
            rx_cnt_q   <= '0;
          end
        end
        RX_START: begin
          if (rx_cnt_q == rx_half) begin
            rx_cnt_q <= '0;
            rx_bit_q <= '0;
            rx_state_q <= rx_sync_q ? RX_IDLE : RX_DATA;
          end else begin
            rx_cnt_q <= rx_cnt_q + DW_ONE;
          end
        end
        RX_DATA: begin
          if (rx_bit_end) begin
            rx_cnt_q   <= '0;
            rx_shift_q <= {rx_sync_q, rx_shift_q[7:1]};
            if (rx_bit_q == 3'd7) rx_state_q <= RX_STOP;
            else                  rx_bit_q   <= rx_bit_q + 3'd1;
          end else begin
            rx_cnt_q <= rx_cnt_q + DW_ONE;
          end
        end
        RX_STOP: begin
          if (rx_bit_end) rx_state_q <= RX_IDLE;
          else            rx_cnt_q   <= rx_cnt_q + DW_ONE;
        end
        default: rx_state_q <= RX_IDLE;
      endcase
    end
  end

  // Control, sticky status and RTS
  always_comb begin
    ctrl_d = ctrl_wr ? reg_wdata[3:0] : ctrl_q;
    ovr_d  = ovr_evt  || (ovr_q  && !stat_rd);
    ferr_d = ferr_evt || (ferr_q && !stat_rd);
    rts_d  = ctrl_q[3] && (rx_count >= RTS_LVL);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_q <= 4'h4;
      ovr_q  <= 1'b0;
      ferr_q <= 1'b0;
      rts_q  <= 1'b0;
    end else begin
      ctrl_q <= ctrl_d;
      ovr_q  <= ovr_d;
      ferr_q <= ferr_d;
      rts_q  <= rts_d;
    end
  end

  logic [7:0] stat_val;
  assign stat_val = {rx_empty, rx_full, ovr_q, ferr_q, tx_full, tx_empty, cts_sync_q, tx_busy_q};

  always_comb begin
    reg_rdata = '0;
    case (reg_addr)
      2'd0:    reg_rdata = {4'b0000, ctrl_q};
      2'd1:    reg_rdata = stat_val;
      2'd2:    reg_rdata = rx_empty ? 8'h00 : rx_head;
      default: reg_rdata = '0;
    endcase
  end

  assign uart_tx    = tx_line_q;
  assign uart_rts_n = rts_q;
endmodule

// File: tb/tb_usb_uart_ctrl.sv
// Directed bench for usb_uart_ctrl: register vector table plus line-level
// sequences for loopback, TX back-pressure, RX overrun/RTS, framing and reset.
module tb_usb_uart_ctrl;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       reg_cs = 1'b0;
  logic [1:0] reg_addr = 2'd0;
  logic       reg_wr_pulse = 1'b0;
  logic       reg_rd_pulse = 1'b0;
  logic [7:0] reg_wdata = 8'h00;
  logic [7:0] reg_rdata;
  logic       uart_rx;
  logic       uart_cts_n = 1'b0;
  logic       uart_tx;
  logic       uart_rts_n;
  logic       rx_drv = 1'b1;
  logic       loop_en = 1'b0;

  int checks = 0;
  int failures = 0;

  assign uart_rx = loop_en ? uart_tx : rx_drv;

  always #5 clk = ~clk;

  usb_uart_ctrl #(.CLK_HZ(48_000_000), .FIFO_DEPTH(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .reg_cs       (reg_cs),
    .reg_addr     (reg_addr),
    .reg_wr_pulse (reg_wr_pulse),
    .reg_rd_pulse (reg_rd_pulse),
    .reg_wdata    (reg_wdata),
    .reg_rdata    (reg_rdata),
    .uart_rx      (uart_rx),
    .uart_cts_n   (uart_cts_n),
    .uart_tx      (uart_tx),
    .uart_rts_n   (uart_rts_n)
  );

  typedef struct {
    bit         rd;
    logic [1:0] addr;
    logic [7:0] wdata;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs [14];

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%02h expected 0x%02h", name, got, exp);
    end
  endtask

  task automatic reg_write(input logic [1:0] a, input logic [7:0] d);
    @(negedge clk);
    reg_cs = 1'b1; reg_addr = a; reg_wdata = d; reg_wr_pulse = 1'b1;
    @(posedge clk);
    #1;
    reg_cs = 1'b0; reg_wr_pulse = 1'b0;
  endtask

  task automatic reg_read(input logic [1:0] a, output logic [7:0] d);
    @(negedge clk);
    reg_cs = 1'b1; reg_addr = a; reg_rd_pulse = 1'b1;
    #1 d = reg_rdata;
    @(posedge clk);
    #1;
    reg_cs = 1'b0; reg_rd_pulse = 1'b0;
  endtask

  task automatic peek(input logic [1:0] a, output logic [7:0] d);
    reg_cs = 1'b1; reg_addr = a;
    #1 d = reg_rdata;
    reg_cs = 1'b0;
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop_bit, input int div);
    @(negedge clk);
    rx_drv = 1'b0;
    repeat (div) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_drv = b[i];
      repeat (div) @(negedge clk);
    end
    rx_drv = stop_bit;
    repeat (div) @(negedge clk);
    rx_drv = 1'b1;
  endtask

  task automatic wait_tx_fall(input int bound, output bit seen);
    seen = 1'b0;
    for (int t = 0; t < bound && !seen; t++) begin
      @(negedge clk);
      if (uart_tx == 1'b0) seen = 1'b1;
    end
  endtask

  // Independent line receiver: returns at the stop-bit centre.
  task automatic capture_tx(input int div, output logic [7:0] b, output bit ok);
    bit seen;
    b = 8'h00;
    ok = 1'b0;
    wait_tx_fall(3000, seen);
    if (seen) begin
      repeat (div / 2) @(negedge clk);
      if (uart_tx == 1'b0) begin
        for (int i = 0; i < 8; i++) begin
          repeat (div) @(negedge clk);
          b[i] = uart_tx;
        end
        repeat (div) @(negedge clk);
        ok = (uart_tx == 1'b1);
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] d, b;
    bit ok, seen;
    int lows, t;

    vecs[0]  = '{1'b1, 2'd0, 8'h00, 8'h04};
    vecs[1]  = '{1'b1, 2'd1, 8'h00, 8'h84};
    vecs[2]  = '{1'b1, 2'd2, 8'h00, 8'h00};
    vecs[3]  = '{1'b1, 2'd3, 8'h00, 8'h00};
    vecs[4]  = '{1'b0, 2'd0, 8'hFF, 8'h00};
    vecs[5]  = '{1'b1, 2'd0, 8'h00, 8'h0F};
    vecs[6]  = '{1'b0, 2'd3, 8'hA5, 8'h00};
    vecs[7]  = '{1'b1, 2'd3, 8'h00, 8'h00};
    vecs[8]  = '{1'b1, 2'd0, 8'h00, 8'h0F};
    vecs[9]  = '{1'b0, 2'd0, 8'h3B, 8'h00};
    vecs[10] = '{1'b1, 2'd0, 8'h00, 8'h0B};
    vecs[11] = '{1'b1, 2'd1, 8'h00, 8'h84};
    vecs[12] = '{1'b0, 2'd0, 8'h04, 8'h00};
    vecs[13] = '{1'b1, 2'd0, 8'h00, 8'h04};

    repeat (4) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_tx", {7'd0, uart_tx}, 8'h01);
    check("rst_rts_n", {7'd0, uart_rts_n}, 8'h00);

    foreach (vecs[i]) begin
      if (vecs[i].rd) begin
        reg_read(vecs[i].addr, d);
        check($sformatf("vec%0d", i), d, vecs[i].exp);
      end else begin
        reg_write(vecs[i].addr, vecs[i].wdata);
      end
    end

    // TX start latency and RX visibility, single byte in loopback
    loop_en = 1'b1;
    reg_write(2'd0, 8'h06);
    reg_write(2'd2, 8'h3C);
    @(posedge clk); #1;
    check("tx_n1_high", {7'd0, uart_tx}, 8'h01);
    @(posedge clk); #1;
    check("tx_n2_low", {7'd0, uart_tx}, 8'h00);
    peek(2'd1, d);
    check("stat_n2_busy", d, 8'h85);
    repeat (454) @(posedge clk);
    #1 peek(2'd1, d);
    check("rx_not_yet", {7'd0, d[7]}, 8'h01);
    repeat (10) @(posedge clk);
    #1 peek(2'd1, d);
    check("rx_visible", {7'd0, d[7]}, 8'h00);
    reg_read(2'd2, d);
    check("loop_single", d, 8'h3C);
    repeat (40) @(posedge clk);
    reg_read(2'd1, d);
    check("stat_after_single", d, 8'h84);

    // Loopback burst of 12 bytes
    for (int i = 0; i < 12; i++) reg_write(2'd2, 8'hA5 + 8'(i));
    peek(2'd1, d);
    check("burst_tx_not_empty", {7'd0, d[2]}, 8'h00);
    seen = 1'b0;
    for (t = 0; t < 1200 && !seen; t++) begin
      @(negedge clk);
      peek(2'd1, d);
      if (d[7] == 1'b0) seen = 1'b1;
    end
    check("burst_first_rx", {7'd0, seen}, 8'h01);
    repeat (5600) @(posedge clk);
    for (int i = 0; i < 12; i++) begin
      reg_read(2'd2, d);
      check($sformatf("burst_byte%0d", i), d, 8'hA5 + 8'(i));
    end
    peek(2'd1, d);
    check("burst_stat_end", d, 8'h84);
    loop_en = 1'b0;

    // TX overflow under CTS back-pressure
    uart_cts_n = 1'b1;
    repeat (4) @(posedge clk);
    reg_write(2'd0, 8'h0E);
    for (int i = 0; i < 17; i++) reg_write(2'd2, 8'h10 + 8'(i));
    peek(2'd1, d);
    check("ovf_stat_full", d, 8'h8A);
    lows = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (uart_tx == 1'b0) lows++;
    end
    check("ovf_tx_held", 8'(lows), 8'h00);
    uart_cts_n = 1'b0;
    for (int i = 0; i < 16; i++) begin
      capture_tx(48, b, ok);
      check($sformatf("ovf_frame%0d_ok", i), {7'd0, ok}, 8'h01);
      check($sformatf("ovf_frame%0d", i), b, 8'h10 + 8'(i));
    end
    wait_tx_fall(1500, seen);
    check("ovf_no_17th", {7'd0, seen}, 8'h00);
    peek(2'd1, d);
    check("ovf_stat_end", d, 8'h84);

    // RX overrun and RTS threshold
    reg_write(2'd0, 8'h0F);
    for (int i = 0; i < 17; i++) begin
      send_rx(8'h40 + 8'(i), 1'b1, 16);
      repeat (3) @(negedge clk);
      if (i == 12) check("rts_at_13", {7'd0, uart_rts_n}, 8'h00);
      if (i == 13) check("rts_at_14", {7'd0, uart_rts_n}, 8'h01);
      if (i == 15) begin
        peek(2'd1, d);
        check("rx_full_no_ovr", d, 8'h44);
      end
    end
    peek(2'd1, d);
    check("rx_ovr_set", d, 8'h64);
    reg_read(2'd1, d);
    check("rx_ovr_read", d, 8'h64);
    reg_read(2'd1, d);
    check("rx_ovr_cleared", d, 8'h44);
    for (int i = 0; i < 16; i++) begin
      reg_read(2'd2, d);
      check($sformatf("rx_byte%0d", i), d, 8'h40 + 8'(i));
    end
    repeat (3) @(negedge clk);
    check("rts_released", {7'd0, uart_rts_n}, 8'h00);
    peek(2'd1, d);
    check("rx_drained", d, 8'h84);

    // Framing error and start-bit glitch
    reg_write(2'd0, 8'h07);
    send_rx(8'h5A, 1'b0, 16);
    repeat (5) @(negedge clk);
    peek(2'd1, d);
    check("ferr_set", d, 8'h94);
    reg_read(2'd1, d);
    check("ferr_read", d, 8'h94);
    peek(2'd1, d);
    check("ferr_cleared", d, 8'h84);
    @(negedge clk) rx_drv = 1'b0;
    repeat (5) @(negedge clk);
    rx_drv = 1'b1;
    repeat (60) @(negedge clk);
    peek(2'd1, d);
    check("glitch_ignored", d, 8'h84);
    send_rx(8'hC3, 1'b1, 16);
    repeat (3) @(negedge clk);
    reg_read(2'd2, d);
    check("after_glitch_byte", d, 8'hC3);

    // Reset during a frame
    reg_write(2'd0, 8'h06);
    reg_write(2'd2, 8'h00);
    reg_write(2'd2, 8'h55);
    repeat (210) @(posedge clk);
    #1 check("rst_tx_bit3_low", {7'd0, uart_tx}, 8'h00);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    check("rst_tx_high", {7'd0, uart_tx}, 8'h01);
    peek(2'd1, d);
    check("rst_stat", d, 8'h84);
    peek(2'd0, d);
    check("rst_ctrl", d, 8'h04);
    @(negedge clk) rst = 1'b0;
    lows = 0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (uart_tx == 1'b0) lows++;
    end
    check("rst_tx_fifo_empty", 8'(lows), 8'h00);
    peek(2'd1, d);
    check("rst_stat_later", d, 8'h84);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
